// File: rtl/dc_pred_multi.sv
// DC intra predictor for CHANNELS planes of BLOCK_SIZE x BLOCK_SIZE blocks.
// Edge samples are latched on accept, summed LANES per cycle, rounded per mode and broadcast.
module dc_pred_multi #(
    parameter int BIT_WIDTH  = 8,
    parameter int BLOCK_SIZE = 8,
    parameter int CHANNELS   = 2,
    parameter int COORD_W    = 10,
    parameter int LANES      = 2
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           start,
    input  logic [COORD_W-1:0]                             x,
    input  logic [COORD_W-1:0]                             y,
    input  logic [CHANNELS*BLOCK_SIZE*BIT_WIDTH-1:0]       top,
    input  logic [CHANNELS*BLOCK_SIZE*BIT_WIDTH-1:0]       left,
    output logic                                           busy,
    output logic                                           done,
    output logic [CHANNELS*BIT_WIDTH-1:0]                  dc,
    output logic [CHANNELS*BLOCK_SIZE*BLOCK_SIZE*BIT_WIDTH-1:0] dst
);

    localparam int STEPS   = BLOCK_SIZE / LANES;
    localparam int LOG2_BS = $clog2(BLOCK_SIZE);
    localparam int ACC_W   = BIT_WIDTH + LOG2_BS + 1;
    localparam int SUM_W   = ACC_W + 1;
    localparam int STEP_W  = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int EDGE_W  = CHANNELS * BLOCK_SIZE * BIT_WIDTH;
    localparam int DC_W    = CHANNELS * BIT_WIDTH;
    localparam int PIX     = BLOCK_SIZE * BLOCK_SIZE;
    localparam int DST_W   = CHANNELS * PIX * BIT_WIDTH;

    localparam logic [STEP_W-1:0]    LAST_STEP = STEP_W'(STEPS - 1);
    localparam logic [SUM_W-1:0]     RND_BOTH  = SUM_W'(BLOCK_SIZE);
    localparam logic [SUM_W-1:0]     RND_ONE   = SUM_W'(BLOCK_SIZE / 2);
    localparam logic [BIT_WIDTH-1:0] DC_MID    = {1'b1, {(BIT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_RND  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [EDGE_W-1:0]   r_top;
    logic [EDGE_W-1:0]   r_left;
    logic                r_use_top;
    logic                r_use_left;
    logic [STEP_W-1:0]   r_step;
    logic [ACC_W-1:0]    r_acc      [CHANNELS];
    logic [ACC_W-1:0]    w_acc_next [CHANNELS];
    logic [SUM_W-1:0]    w_sum      [CHANNELS];
    logic                r_busy;
    logic                r_done;
    logic [DC_W-1:0]     r_dc;
    logic [DST_W-1:0]    r_dst;
    logic [DC_W-1:0]     w_dc;
    logic [DST_W-1:0]    w_dst;
    logic                w_has_edge;

    assign w_has_edge = (x != {COORD_W{1'b0}}) || (y != {COORD_W{1'b0}});

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; NONE skips accumulation entirely
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_has_edge ? S_ACC : S_RND;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_ACC: begin
                if (r_step == LAST_STEP) begin
                    w_next = S_RND;
                end else begin
                    w_next = S_ACC;
                end
            end
            S_RND:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Per-channel partial sum of the enabled edges for the current step
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            w_acc_next[c] = r_acc[c];
            for (int l = 0; l < LANES; l++) begin
                if (r_use_top) begin
                    w_acc_next[c] = w_acc_next[c] + ACC_W'(r_top[((c * BLOCK_SIZE) + (int'(r_step) * LANES) + l) * BIT_WIDTH +: BIT_WIDTH]);
                end else begin
                    w_acc_next[c] = w_acc_next[c];
                end
                if (r_use_left) begin
                    w_acc_next[c] = w_acc_next[c] + ACC_W'(r_left[((c * BLOCK_SIZE) + (int'(r_step) * LANES) + l) * BIT_WIDTH +: BIT_WIDTH]);
                end else begin
                    w_acc_next[c] = w_acc_next[c];
                end
            end
        end
    end

    // Mode-dependent rounding; the extra sum bit keeps the rounding add exact
    always_comb begin
        w_dc = {DC_W{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            w_sum[c] = {1'b0, r_acc[c]};
            if (r_use_top && r_use_left) begin
                w_dc[c*BIT_WIDTH +: BIT_WIDTH] = BIT_WIDTH'((w_sum[c] + RND_BOTH) >> (LOG2_BS + 1));
            end else if (r_use_top || r_use_left) begin
                w_dc[c*BIT_WIDTH +: BIT_WIDTH] = BIT_WIDTH'((w_sum[c] + RND_ONE) >> LOG2_BS);
            end else begin
                w_dc[c*BIT_WIDTH +: BIT_WIDTH] = DC_MID;
            end
        end
    end

    // Broadcast each channel's DC value over its whole block
    always_comb begin
        w_dst = {DST_W{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            for (int p = 0; p < PIX; p++) begin
                w_dst[(c*PIX + p)*BIT_WIDTH +: BIT_WIDTH] = w_dc[c*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_top      <= {EDGE_W{1'b0}};
            r_left     <= {EDGE_W{1'b0}};
            r_use_top  <= 1'b0;
            r_use_left <= 1'b0;
            r_step     <= {STEP_W{1'b0}};
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dc       <= {DC_W{1'b0}};
            r_dst      <= {DST_W{1'b0}};
            for (int c = 0; c < CHANNELS; c++) begin
                r_acc[c] <= {ACC_W{1'b0}};
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_top      <= top;
                        r_left     <= left;
                        r_use_top  <= (y != {COORD_W{1'b0}});
                        r_use_left <= (x != {COORD_W{1'b0}});
                        r_step     <= {STEP_W{1'b0}};
                        r_busy     <= 1'b1;
                        for (int c = 0; c < CHANNELS; c++) begin
                            r_acc[c] <= {ACC_W{1'b0}};
                        end
                    end
                end
                S_ACC: begin
                    r_done <= 1'b0;
                    r_step <= r_step + STEP_W'(1);
                    for (int c = 0; c < CHANNELS; c++) begin
                        r_acc[c] <= w_acc_next[c];
                    end
                end
                S_RND: begin
                    r_done <= 1'b0;
                    r_dc   <= w_dc;
                    r_dst  <= w_dst;
                end
                S_DONE: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign dc   = r_dc;
    assign dst  = r_dst;

endmodule

// File: tb/tb_dc_pred_multi.sv
// Self-checking bench for dc_pred_multi at default parameters: directed table,
// multi-cycle corner sequences and randomized requests against an arithmetic model.
module tb_dc_pred_multi;

    localparam int BW    = 8;
    localparam int BS    = 8;
    localparam int CH    = 2;
    localparam int LN    = 2;
    localparam int STEPS = BS / LN;

    logic          clk;
    logic          rst;
    logic          start;
    logic [9:0]    x;
    logic [9:0]    y;
    logic [127:0]  top;
    logic [127:0]  left;
    logic          busy;
    logic          done;
    logic [15:0]   dc;
    logic [1023:0] dst;

    int checks   = 0;
    int failures = 0;

    dc_pred_multi #(
        .BIT_WIDTH(BW), .BLOCK_SIZE(BS), .CHANNELS(CH), .COORD_W(10), .LANES(LN)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .top(top), .left(left),
        .busy(busy), .done(done), .dc(dc), .dst(dst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]   x;
        logic [9:0]   y;
        logic [127:0] top;
        logic [127:0] left;
        logic [7:0]   e0;
        logic [7:0]   e1;
        int           lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every pixel of channel c must equal the expected DC of that channel
    task automatic chk_dst(input string name, input logic [7:0] e0, input logic [7:0] e1);
        logic [1023:0] exp;
        for (int p = 0; p < BS*BS; p++) begin
            exp[p*8 +: 8]           = e0;
            exp[(BS*BS + p)*8 +: 8] = e1;
        end
        checks++;
        if (dst !== exp) begin
            failures++;
            $display("FAIL %s: dst got %0h expected all %0h/%0h", name, dst, e0, e1);
        end
    endtask

    function automatic logic [7:0] model_dc(input logic [9:0] xi, input logic [9:0] yi,
                                            input logic [127:0] t, input logic [127:0] l,
                                            input int c);
        int st = 0;
        int sl = 0;
        for (int i = 0; i < BS; i++) begin
            st += int'(t[(c*BS + i)*8 +: 8]);
            sl += int'(l[(c*BS + i)*8 +: 8]);
        end
        if (xi != 0 && yi != 0) return 8'((st + sl + BS) / (2*BS));
        else if (yi != 0)       return 8'((st + BS/2) / BS);
        else if (xi != 0)       return 8'((sl + BS/2) / BS);
        else                    return 8'd128;
    endfunction

    // Counts edges after edge k0 until done rises; busy must stay high until then
    task automatic wait_done(input int k0, output int lat, output bit to);
        lat = 0;
        to  = 1'b1;
        for (int k = k0 + 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                to  = 1'b0;
                chk("busy_low_at_done", 64'(busy), 64'd0);
                break;
            end
            chk("busy_high_while_running", 64'(busy), 64'd1);
        end
        if (to) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done expected done within 60 cycles");
        end
    endtask

    task automatic issue(input vec_t v);
        @(negedge clk);
        x = v.x; y = v.y; top = v.top; left = v.left; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_accept", 64'(busy), 64'd1);
    endtask

    task automatic check_result(input string name, input logic [7:0] e0, input logic [7:0] e1,
                                input int elat, input int lat, input bit to);
        if (!to) begin
            chk({name, "_latency"}, 64'(lat), 64'(elat));
            chk({name, "_dc0"}, 64'(dc[7:0]), 64'(e0));
            chk({name, "_dc1"}, 64'(dc[15:8]), 64'(e1));
            chk_dst(name, e0, e1);
            @(posedge clk); #1;
            chk({name, "_done_one_cycle"}, 64'(done), 64'd0);
        end
    endtask

    vec_t vecs [4];
    vec_t v;
    int   lat;
    bit   to;
    int   d0, d1;
    bit   spurious;

    initial begin
        vecs[0] = '{10'd1, 10'd1,
                    128'hFFFFFFFFFFFFFFFF_0A0A0A0A0A0A0A0A,
                    128'hFFFFFFFFFFFFFFFF_1414141414141414, 8'd15, 8'd255, STEPS + 2};
        vecs[1] = '{10'd0, 10'd5,
                    128'h0909090909090909_0706050403020100,
                    128'h3333333333333333_FFFFFFFFFFFFFFFF, 8'd4, 8'd9, STEPS + 2};
        vecs[2] = '{10'd3, 10'd0,
                    128'hF0F0F0F0F0F0F0F0_F0F0F0F0F0F0F0F0,
                    128'h0201020102010201_6464646464646464, 8'd100, 8'd2, STEPS + 2};
        vecs[3] = '{10'd0, 10'd0,
                    128'h123456789ABCDEF0_0FEDCBA987654321,
                    128'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF, 8'd128, 8'd128, 2};

        rst = 1'b1; start = 1'b0; x = '0; y = '0; top = '0; left = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_dc", 64'(dc), 64'd0);
        chk("reset_dst_zero", 64'(dst == '0), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 4; i++) begin
            issue(vecs[i]);
            wait_done(0, lat, to);
            check_result($sformatf("table%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].lat, lat, to);
        end

        // Inputs and start change while busy: latched samples rule, second start ignored
        issue(vecs[0]);
        @(negedge clk);
        top = ~vecs[0].top; left = 128'h0; x = '0; y = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1, lat, to);
        check_result("busy_restart", 8'd15, 8'd255, STEPS + 2, lat, to);
        spurious = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) spurious = 1'b1;
        end
        chk("busy_restart_no_second_op", 64'(spurious), 64'd0);

        // Start held high: ignored in DONE, accepted on the next IDLE edge
        @(negedge clk);
        x = vecs[1].x; y = vecs[1].y; top = vecs[1].top; left = vecs[1].left; start = 1'b1;
        d0 = -1; d1 = -1;
        for (int k = 0; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done && d0 < 0) d0 = k;
            else if (done && d1 < 0) d1 = k;
        end
        start = 1'b0;
        chk("b2b_first_latency", 64'(d0), 64'(STEPS + 2));
        chk("b2b_issue_interval", 64'(d1 - d0), 64'(STEPS + 3));
        repeat (STEPS + 5) @(posedge clk);

        // Reset during ACC step 2 aborts the operation with outputs cleared at once
        issue(vecs[0]);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_dc", 64'(dc), 64'd0);
        chk("abort_dst_zero", 64'(dst == '0), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        spurious = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done || busy) spurious = 1'b1;
        end
        chk("abort_no_done", 64'(spurious), 64'd0);
        issue(vecs[1]);
        wait_done(0, lat, to);
        check_result("after_abort", 8'd4, 8'd9, STEPS + 2, lat, to);

        // Randomized requests against the arithmetic model
        for (int n = 0; n < 40; n++) begin
            v.x    = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(1, 1023)) : 10'd0;
            v.y    = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(1, 1023)) : 10'd0;
            v.top  = {$urandom, $urandom, $urandom, $urandom};
            v.left = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 3) == 0) v.top  = {128{1'b1}};
            if ($urandom_range(0, 3) == 0) v.left = {128{1'b1}};
            v.e0  = model_dc(v.x, v.y, v.top, v.left, 0);
            v.e1  = model_dc(v.x, v.y, v.top, v.left, 1);
            v.lat = (v.x != 0 || v.y != 0) ? STEPS + 2 : 2;
            issue(v);
            @(negedge clk);
            top = {$urandom, $urandom, $urandom, $urandom};
            left = {$urandom, $urandom, $urandom, $urandom};
            wait_done(0, lat, to);
            check_result($sformatf("rand%0d", n), v.e0, v.e1, v.lat, lat, to);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dc_pred_multi.md
Name: dc_pred_multi

Overview:
Parametrised DC intra predictor for N chroma/luma channels of square BLOCK_SIZE x BLOCK_SIZE blocks. It replaces the fixed 8x8 U/V DC predictor.
- Registers the edge samples at start, so inputs may change afterwards.
- Sums top and/or left edges using LANES samples per edge per cycle.
- Applies mode-correct rounding for BOTH, TOP, LEFT and NONE.
- Drives the filled prediction blocks and per-channel DC values with a one-cycle done pulse.
- Sits between the neighbour-sample fetch and the residual/SAD stage.

Parameters:
BIT_WIDTH, 8, sample width in bits.
BLOCK_SIZE, 8, block edge length; power of two, 4..32.
CHANNELS, 2, independent planes predicted in parallel (e.g. U,V).
COORD_W, 10, width of x/y block coordinates.
LANES, 2, samples per edge per channel accumulated each cycle; power of two, divides BLOCK_SIZE.

Ports:
clk  in  1  clock.
rst  in  1  reset; asynchronous and active-high.
start  in  1  request; accepted only in IDLE.
x  in  COORD_W  block column; non-zero means the left edge is available.
y  in  COORD_W  block row; non-zero means the top edge is available.
top  in  CHANNELS*BLOCK_SIZE*BIT_WIDTH  top edge; channel c, sample i at bits [(c*BLOCK_SIZE+i)*BIT_WIDTH +: BIT_WIDTH].
left  in  CHANNELS*BLOCK_SIZE*BIT_WIDTH  left edge; same packing as top.
busy  out  1  high from the accept edge until done is asserted.
done  out  1  one-cycle pulse; dc and dst are valid from this cycle.
dc  out  CHANNELS*BIT_WIDTH  DC value per channel.
dst  out  CHANNELS*BLOCK_SIZE*BLOCK_SIZE*BIT_WIDTH  every pixel of channel c equals dc[c]; channel c occupies bits [c*BLOCK_SIZE*BLOCK_SIZE*BIT_WIDTH +: ...].

Behaviour:
- Reset (rst=1, asynchronous): state IDLE; busy=0, done=0, dc=0, dst=0; accumulators, step counter and sample registers cleared. Reset asserted mid-operation aborts the operation immediately and produces no done.
- STEPS = BLOCK_SIZE/LANES. ACC_W = BIT_WIDTH+$clog2(BLOCK_SIZE)+1.
- States: IDLE, ACC, RND, DONE.
- Accept: in IDLE with start=1 at a clock edge:
  - latch top, left and the mode;
  - mode = BOTH (x!=0, y!=0), TOP (x==0, y!=0), LEFT (x!=0, y==0), NONE (both zero);
  - clear accumulators; busy<=1.
  - Next state is ACC, or RND for NONE.
- start in any other state is ignored; no queueing.
- ACC: each cycle, step s (0..STEPS-1) adds samples s*LANES .. s*LANES+LANES-1 of each enabled edge per channel. TOP adds top only, LEFT adds left only, BOTH adds both. After step STEPS-1, go to RND.
- RND: compute per channel, result truncated to BIT_WIDTH (cannot overflow):
  - BOTH: (sum + BLOCK_SIZE) >> log2(2*BLOCK_SIZE);
  - TOP/LEFT: (sum + BLOCK_SIZE/2) >> log2(BLOCK_SIZE);
  - NONE: 1 << (BIT_WIDTH-1).
  - Register into dc and dst; go to DONE.
- DONE: done=1 for exactly one cycle, busy=0; next state IDLE.
- Output update rule: dc and dst change only on the edge that enters DONE and hold until the next completion.
- Latency from the accept edge to the edge that raises done:
  - STEPS+2 for BOTH/TOP/LEFT (6 at defaults);
  - 2 for NONE.
- Back-to-back: start may be high in the DONE cycle. It is ignored there and accepted on the following IDLE edge; minimum issue interval is STEPS+3 cycles.
- Unused edges (left in TOP mode, top in LEFT mode, both in NONE) never affect the result.

Test Plan:
1. Defaults, x=1, y=1; ch0 top all 10, left all 20; ch1 top and left all 255 → ch0 sum 240, dc0=15; ch1 dc1=255 (no overflow). done exactly 6 edges after accept; all 64 ch0 pixels = 15.
2. x=0, y=5; ch0 top = 0,1,...,7, left all 0xFF; ch1 top all 9 → dc0=(28+4)>>3=4, dc1=9; left ignored.
3. x=3, y=0; ch0 left all 100; ch1 left = 1,2,1,2,... → dc0=100, dc1=(12+4)>>3=2.
4. x=0, y=0 → dc0=dc1=128, dst all 0x80, done 2 edges after accept, busy high for exactly 2 cycles.
5. Accept a BOTH request, then on the next cycle change top/left and pulse start again while busy → result matches the originally latched samples; only one done; the second start produces no effect.
6. Assert rst for one cycle during step 2 of ACC → busy, done, dc, dst read 0 immediately. No done follows. A fresh start then completes normally with the correct value.
